// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with single-outstanding imem port, stall and redirect.
// Ports:
//   clk, rst (async assert, active-low)
//   StallF, PCSrcE, PCTargetE     : hazard unit stall, execute-stage redirect and target
//   imem_req, imem_addr           : fetch request and word-aligned address
//   imem_gnt, imem_rvalid, imem_rdata : memory grant, response valid, response word
//   InstrFD, PCF_curr, PCPlus4FD, FetchValidF : outputs to the Fetch/Decode register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrFD,
    output logic [31:0] PCF_curr,
    output logic [31:0] PCPlus4FD,
    output logic        FetchValidF
);
    typedef enum logic [1:0] {BOOT, REQ, WAIT, VALID} state_t;
    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        drop_q;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    assign target      = {PCTargetE[31:2], 2'b00};
    assign pc_plus4    = pc_q + 32'd4;
    assign imem_req    = state == REQ;
    assign imem_addr   = pc_q;
    assign FetchValidF = state == VALID;
    assign InstrFD     = state == VALID ? instr_q : NOP_INSTR;
    assign PCF_curr    = pc_q;
    assign PCPlus4FD   = pc_plus4;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (PCSrcE) pc_q <= target;
                    // a grant coinciding with a redirect launches a fetch for the old PC
                    if (imem_gnt) begin
                        state  <= WAIT;
                        drop_q <= PCSrcE;
                    end
                end
                WAIT: begin
                    if (PCSrcE) pc_q <= target;
                    if (imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (!drop_q && !PCSrcE) begin
                            instr_q <= imem_rdata;
                            state   <= VALID;
                        end else begin
                            state <= REQ;
                        end
                    end else if (PCSrcE) begin
                        drop_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (PCSrcE) begin
                        pc_q  <= target;
                        state <= REQ;
                    end else if (!StallF) begin
                        pc_q  <= pc_plus4;
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage of the pipelined RV32I core, directly upstream of the Fetch/Decode pipeline register.
- Owns the PC, issues requests on a request/grant/response instruction-memory port, and handles stall and branch/jump redirect.
- Presents one instruction per fetch to the Fetch/Decode register, together with its PC and PC+4.
- Drives a NOP bubble whenever no valid instruction is available.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven when no valid instruction.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; synchronous deassert assumed.
- StallF  in  1  hazard unit: hold the current fetch output.
- PCSrcE  in  1  execute stage: redirect taken this cycle.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; bits [1:0] always 00.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction word.
- InstrFD  out  32  instruction to the Fetch/Decode register.
- PCF_curr  out  32  PC of InstrFD.
- PCPlus4FD  out  32  PCF_curr + 4, modulo 2^32.
- FetchValidF  out  1  InstrFD holds a real instruction.

## Operation
- Registers:
  - pc_q (32 bits), the address of the current or next fetch.
  - instr_q (32 bits).
  - drop_q (1 bit), discard the next response.
  - 2-bit state.
- States:
  - BOOT: reset state. imem_req=0. Goes to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc_q.
    - imem_gnt goes to WAIT.
    - If PCSrcE coincides with imem_gnt, the granted fetch is stale: set drop_q and load pc_q from the target.
    - PCSrcE without imem_gnt: load pc_q from the target and stay in REQ (imem_addr changes next cycle).
  - WAIT: imem_req=0; one fetch is outstanding.
    - On imem_rvalid with drop_q=1: clear drop_q and go to REQ; the data is discarded.
    - On imem_rvalid with drop_q=0 and PCSrcE=0: instr_q<=imem_rdata and go to VALID.
    - On imem_rvalid with drop_q=0 and PCSrcE=1: discard the data, load pc_q from the target, go to REQ.
    - PCSrcE without imem_rvalid: set drop_q, load pc_q from the target, stay in WAIT.
  - VALID: FetchValidF=1, InstrFD=instr_q.
    - PCSrcE (priority over StallF): load pc_q from the target, go to REQ.
    - Else StallF=0: pc_q<=pc_q+4, go to REQ (the instruction is consumed by the Fetch/Decode register this edge).
    - Else hold.
- Output values:
  - Outside VALID, InstrFD=NOP_INSTR and FetchValidF=0.
  - PCF_curr=pc_q and PCPlus4FD=pc_q+4 in every state.
- Loading pc_q from the redirect target always means pc_q <= {PCTargetE[31:2],2'b00}.
- pc_q+4 wraps 32'hFFFF_FFFC to 32'h0000_0000.
- imem_rvalid outside WAIT is ignored; this covers stale responses after a mid-flight reset.
- At most one fetch is outstanding.
- StallF does not affect REQ or WAIT: the fetch still proceeds.

## Timing
- Reset values:
  - State BOOT, pc_q=RESET_PC, instr_q=NOP_INSTR, drop_q=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, InstrFD=NOP_INSTR, PCF_curr=RESET_PC, PCPlus4FD=RESET_PC+4, FetchValidF=0.
- Outputs are driven from registers plus the +4 adder only. There is no combinational path from any imem_* input to any *FD output.
- With zero-wait memory (gnt in the REQ cycle, rvalid the next cycle), steady state is one instruction per 3 cycles: REQ, WAIT, VALID.
- Redirect latency: PCSrcE in cycle N means imem_addr = the target in cycle N+1 (states REQ or VALID).
- The first valid instruction after reset deassertion appears no earlier than cycle 4: BOOT, REQ, WAIT, VALID.
- Reset asserted in any state returns to BOOT immediately and clears drop_q.

## Test plan
- Reset release, zero-wait memory returning 32'h0010_0093 for address 0 -> imem_req is high in cycle 2 with addr 0. Cycle 4: FetchValidF=1, InstrFD=32'h0010_0093, PCF_curr=0, PCPlus4FD=4. Next request is at addr 4.
- StallF held 5 cycles while in VALID -> outputs are stable for all 5 cycles, pc_q does not advance, and the next request is at PC+4 after release.
- PCSrcE=1 with PCTargetE=32'h0000_0102 while in WAIT, then rvalid 2 cycles later -> the response is dropped, FetchValidF stays 0, and the next request is at 32'h0000_0100.
- Redirect coinciding with imem_gnt, and separately with imem_rvalid -> that fetch is never presented as valid, and the next request is at the target.
- pc_q=32'hFFFF_FFFC in VALID with StallF=0 -> PCPlus4FD=0, and the next request is at 32'h0000_0000.
- rst pulsed low while in WAIT, then a stale rvalid arrives in BOOT or REQ -> the response is ignored, and the first valid instruction comes from RESET_PC.
